// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI master and the matching slave:
//               command encodings, controller state encoding, frame lengths
//               and a small command-decode helper.
// Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    // Two-bit command field sent ahead of every payload byte.
    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Outbound frame: 2 command bits followed by 8 payload bits.
    localparam logic [3:0] BIT_COUNT = 4'd10;
    // Inbound read byte length.
    localparam logic [3:0] RX_BITS   = 4'd8;

    // Transaction controller states (explicit 3-bit encoding).
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RECV  = 3'd4,
        ST_END   = 3'd5
    } state_e;

    // Only the read-data command turns the bus around to receive a byte.
    function automatic logic is_read_data(input logic [1:0] cmd);
        return (cmd == CMD_RD_DATA);
    endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// Module      : spi_master
// Description : Single-request SPI master. Sends a 2-bit command plus an
//               8-bit payload MSB first, then for read-data commands waits
//               READ_WAIT cycles and shifts in one byte from MISO.
//               One MOSI bit per clock; SS_n frames the whole transaction.
//
// Parameters  : READ_WAIT  turnaround cycles before the first MISO sample
//                          on a read-data command (0..7, 0 = no wait)
// Ports       : clk        rising-edge clock
//               rst        synchronous active-high reset
//               req_valid  request present
//               req_ready  block idle, request accepted this cycle
//               req_cmd    2-bit command
//               req_data   8-bit payload (dummy on read-data)
//               rsp_valid  one-cycle pulse at transaction end
//               rsp_data   received byte on read-data, else 0x00; held
//               SS_n       slave select, active low
//               MOSI       serial data out
//               MISO       serial data in
// Revision    : 1.0  initial release
// ============================================================================
module spi_master
    import spi_pkg::*;
#(
    parameter int READ_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_cmd,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    // Last value of the wait counter before moving to RECV. Unused when
    // READ_WAIT is 0 because WAIT is then bypassed entirely.
    localparam logic [3:0] WAIT_LAST = (READ_WAIT == 0) ? 4'd0 : 4'(READ_WAIT - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q,   cnt_d;       // shared bit / wait / receive counter
    logic [1:0] cmd_q,   cmd_d;       // latched command, selects read path
    logic [9:0] tx_q,    tx_d;        // outbound frame, MSB is next bit
    logic [7:0] rx_q,    rx_d;        // inbound shift register
    logic       ss_n_q,  ss_n_d;
    logic       mosi_q,  mosi_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q,  rsp_data_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            cmd_q       <= 2'b00;
            tx_q        <= 10'd0;
            rx_q        <= 8'd0;
            ss_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            ss_n_q      <= ss_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Pin outputs are registered and
    // derived from the state being entered, so they line up exactly with
    // the state they belong to.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        mosi_d     = 1'b0;
        rsp_data_d = rsp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_START;
                    cmd_d   = req_cmd;
                    tx_d    = {req_cmd, req_data};
                    cnt_d   = 4'd0;
                end
            end

            ST_START: begin
                // Present the first frame bit for the first SHIFT cycle.
                state_d = ST_SHIFT;
                cnt_d   = 4'd0;
                mosi_d  = tx_q[9];
                tx_d    = {tx_q[8:0], 1'b0};
            end

            ST_SHIFT: begin
                if (cnt_q == BIT_COUNT - 4'd1) begin
                    cnt_d = 4'd0;
                    if (is_read_data(cmd_q)) begin
                        state_d = (READ_WAIT == 0) ? ST_RECV : ST_WAIT;
                    end else begin
                        state_d    = ST_END;
                        rsp_data_d = 8'h00;
                    end
                end else begin
                    cnt_d  = cnt_q + 4'd1;
                    mosi_d = tx_q[9];
                    tx_d   = {tx_q[8:0], 1'b0};
                end
            end

            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RECV;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_RECV: begin
                rx_d = {rx_q[6:0], MISO};
                if (cnt_q == RX_BITS - 4'd1) begin
                    cnt_d      = 4'd0;
                    state_d    = ST_END;
                    // Capture the final bit directly so the byte is complete
                    // in the END cycle.
                    rsp_data_d = {rx_q[6:0], MISO};
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_END: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Slave select is released in END and IDLE only.
        ss_n_d      = (state_d == ST_IDLE) || (state_d == ST_END);
        rsp_valid_d = (state_d == ST_END);
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign SS_n      = ss_n_q;
    assign MOSI      = mosi_q;

endmodule : spi_master
`default_nettype wire

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter READ_WAIT, default 2: cycles between the last MOSI bit and the first MISO sample on a read-data command, range 0..7.
REQ-002 SHALL have port clk, input, 1: the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1: a request is present.
REQ-005 SHALL have port req_ready, output, 1: the block is idle and accepts a request this cycle.
REQ-006 SHALL have port req_cmd, input, 2: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
REQ-007 SHALL have port req_data, input, 8: the payload; dummy bits on read-data.
REQ-008 SHALL have port rsp_valid, output, 1: one-cycle pulse at transaction end.
REQ-009 SHALL have port rsp_data, output, 8: read byte on cmd 11, otherwise 0x00.
REQ-010 SHALL have port SS_n, output, 1: slave select, active low.
REQ-011 SHALL have port MOSI, output, 1: serial data to the slave.
REQ-012 SHALL have port MISO, input, 1: serial data from the slave.

Function
REQ-013 SHALL accept a request on a rising edge when req_valid=1 and req_ready=1; this is cycle 0; cmd and data are latched.
REQ-014 SHALL assert req_ready only in IDLE.
REQ-015 SHALL implement states IDLE, START, SHIFT, WAIT, RECV, END.
REQ-016 SHALL transition IDLE->START on accept.
REQ-017 SHALL drive SS_n=0 and MOSI=0 during START, which lasts 1 cycle (cycle 1).
REQ-018 SHALL, in SHIFT, drive 10 bits on cycles 2..11, one bit per cycle, registered: req_cmd[1], req_cmd[0], then req_data[7] down to req_data[0].
REQ-019 SHALL go SHIFT->END after bit 10 for cmd 00, 01 and 10, and SHIFT->WAIT for cmd 11.
REQ-020 SHALL keep SS_n=0 and MOSI=0 for READ_WAIT cycles in WAIT; READ_WAIT=0 means WAIT is skipped.
REQ-021 SHALL, in RECV, sample MISO on 8 consecutive rising edges, MSB first, into an 8-bit shift register, then go to END.
REQ-022 SHALL, in END, drive SS_n=1 and MOSI=0 for 1 cycle, pulse rsp_valid, present rsp_data, then return to IDLE.
REQ-023 SHALL hold rsp_data stable until the next rsp_valid.
REQ-024 SHALL give an accept-to-rsp_valid latency of 12 cycles for cmd 00/01/10 and 20+READ_WAIT cycles for cmd 11.
REQ-025 SHALL keep SS_n=1 for at least the END cycle plus the IDLE cycle between back-to-back transactions, so SS_n is high for 2 cycles minimum.
REQ-026 SHALL ignore req_* while not in IDLE, with no queuing.
REQ-027 SHALL ignore MISO outside RECV.
REQ-028 SHALL not check command order (for example, read-data without a preceding read-addr); commands are sent verbatim.

Reset
REQ-029 SHALL, on a rising edge with rst=1, set: state=IDLE, SS_n=1, MOSI=0, req_ready=1, rsp_valid=0, rsp_data=0x00, counters=0.
REQ-030 SHALL let rst asserted mid-transaction abort it: SS_n=1 on the next cycle and no rsp_valid for the aborted request.
REQ-031 SHALL make rst take priority over a simultaneous req_valid.

Structure
REQ-032 SHALL put the command encodings (CMD_WR_ADDR=00, CMD_WR_DATA=01, CMD_RD_ADDR=10, CMD_RD_DATA=11), the state encoding and the bit-count constant 10 in shared package spi_pkg, used by the slave as well.
REQ-033 SHALL be one flat module with no sub-modules; the bit and wait counters are 4 bits wide.

Verification
REQ-034 SHALL cover: cmd 00, data 0xFE -> SS_n low on cycles 1-11; MOSI on cycles 2..11 = 0,0,1,1,1,1,1,1,1,0; rsp_valid on cycle 12 with rsp_data 0x00.
REQ-035 SHALL cover: cmd 01, data 0xAA -> MOSI = 0,1,1,0,1,0,1,0,1,0; rsp_valid on cycle 12.
REQ-036 SHALL cover: cmd 11, data 0xF0, READ_WAIT=2, MISO model drives 0xAA MSB first on cycles 14-21 -> MOSI = 1,1,1,1,1,1,0,0,0,0; rsp_valid on cycle 22 with rsp_data 0xAA.
REQ-037 SHALL cover: full sequence against the spi_slave+RAM top (write-addr 0xFE, write-data 0xAA, read-addr 0xFE, read-data) -> final rsp_data 0xAA.
REQ-038 SHALL cover: req_valid held high for two back-to-back requests -> second accepted one cycle after END; SS_n high for exactly 2 cycles between them; req_ready=0 throughout each transaction.
REQ-039 SHALL cover: rst asserted at cycle 6 of a cmd 01 transaction -> SS_n=1 and req_ready=1 the next cycle, no rsp_valid; a following cmd 00 request completes normally.
